dmem_responder: RTL

//  Data-memory responder for the core's load/store port: the target end of the

---
 rtl/dmem_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT wait
// states, performs a byte-masked access and holds the response until taken.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_access;
    logic            w_acc_we;
    logic [31:0]     w_acc_addr;
    logic [31:0]     w_acc_wdata;
    logic [3:0]      w_acc_be;
    logic            w_acc_err;
    logic [IDX_W-1:0] w_idx;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    // With WAIT==0 the access happens on the accept edge, so use the live request.
    assign w_acc_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_acc_be    = (r_state == S_IDLE) ? req_be    : r_be;
    assign w_acc_err   = addr_err(w_acc_addr);
    assign w_idx       = w_acc_addr[IDX_W+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = (WAIT == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_RESP);
        w_accept  = req_ready && req_valid;
        w_access  = (w_accept && (WAIT == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                if (WAIT > 0) r_cnt <= 4'(WAIT - 1);
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_err   <= w_acc_err;
                r_rdata <= (w_acc_err || w_acc_we) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Memory contents survive reset; only the handshake state is cleared.
    always_ff @(posedge clk) begin
        if (w_access && w_acc_we && !w_acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_be[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
